// File: rtl/i2c_slave_mem.sv
// rtl/i2c_slave_mem.sv - I2C target with byte-addressed register memory and pointer auto-increment
// Open-drain SDA via sda_oe; SCL is only observed, never stretched.
module i2c_slave_mem #(
    parameter logic [6:0] SLV_ADDR    = 7'h50,
    parameter int         DEPTH       = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_oe,
    output logic                     busy,
    output logic                     wr_stb,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic [7:0]               wr_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;

    state_t        r_state;
    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_rw;
    logic          r_wr_pend;
    logic [AW-1:0] r_ptr;
    logic          r_sda_oe;
    logic          r_busy;
    logic          r_wr_stb;
    logic [AW-1:0] r_wr_addr;
    logic [7:0]    r_wr_data;
    logic [7:0]    r_mem [DEPTH];

    logic       w_scl;
    logic       w_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_byte;

    // Synchronizers reset to 1 so an idle bus shows no edges after reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = r_sda_d & ~w_sda & w_scl & r_scl_d;
    assign w_stop     = ~r_sda_d & w_sda & w_scl & r_scl_d;
    assign w_byte     = {r_shift[6:0], w_sda};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_rw      <= 1'b0;
            r_wr_pend <= 1'b0;
            r_ptr     <= '0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_wr_stb <= 1'b0;
            // Memory write lands one clk after the 8th data bit is shifted in
            if (r_wr_pend) begin
                r_wr_pend      <= 1'b0;
                r_mem[r_ptr]   <= r_shift;
                r_wr_stb       <= 1'b1;
                r_wr_addr      <= r_ptr;
                r_wr_data      <= r_shift;
                r_ptr          <= r_ptr + PTR_ONE;
            end

            if (w_stop) begin
                r_state  <= IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else if (w_start) begin
                r_state   <= ADDR;
                r_bit_cnt <= '0;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: ;
                    ADDR: if (w_scl_rise) begin
                        r_shift <= w_byte;
                        if (r_bit_cnt == 4'd7) begin
                            r_bit_cnt <= '0;
                            if (w_byte[7:1] == SLV_ADDR) begin
                                r_busy  <= 1'b1;
                                r_rw    <= w_byte[0];
                                r_state <= ADDR_ACK;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= IDLE;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                    // First fall asserts ACK, second fall ends the ACK clock
                    ADDR_ACK, PTR_ACK, WR_ACK: if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd0) begin
                            r_sda_oe  <= 1'b1;
                            r_bit_cnt <= 4'd1;
                        end else if (r_state == ADDR_ACK && r_rw) begin
                            r_shift   <= {r_mem[r_ptr][6:0], 1'b0};
                            r_sda_oe  <= ~r_mem[r_ptr][7];
                            r_bit_cnt <= 4'd1;
                            r_state   <= RD_DATA;
                        end else begin
                            r_sda_oe  <= 1'b0;
                            r_bit_cnt <= '0;
                            r_state   <= (r_state == ADDR_ACK) ? PTR : WR_DATA;
                        end
                    end
                    PTR: if (w_scl_rise) begin
                        r_shift <= w_byte;
                        if (r_bit_cnt == 4'd7) begin
                            r_ptr     <= w_byte[AW-1:0];
                            r_bit_cnt <= '0;
                            r_state   <= PTR_ACK;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                    WR_DATA: if (w_scl_rise) begin
                        r_shift <= w_byte;
                        if (r_bit_cnt == 4'd7) begin
                            r_wr_pend <= 1'b1;
                            r_bit_cnt <= '0;
                            r_state   <= WR_ACK;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                    RD_DATA: if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            r_sda_oe  <= 1'b0;
                            r_ptr     <= r_ptr + PTR_ONE;
                            r_bit_cnt <= '0;
                            r_state   <= RD_ACK;
                        end else begin
                            r_sda_oe  <= ~r_shift[7];
                            r_shift   <= {r_shift[6:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                    RD_ACK: if (w_scl_rise) begin
                        if (!w_sda) begin
                            r_shift   <= r_mem[r_ptr];
                            r_bit_cnt <= '0;
                            r_state   <= RD_DATA;
                        end else begin
                            r_sda_oe <= 1'b0;
                            r_state  <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign sda_oe  = r_sda_oe;
    assign busy    = r_busy;
    assign wr_stb  = r_wr_stb;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule
